fft_out_reader: RTL

Result unloader for the in-place FFT core. After the butterfly sequencer finishes all M levels, this block reads the 2^M complex results out of the FFT working RAM and streams them to downstream logic in natural frequency order. Downstream is the peak search and magnitude logic of the tuner. It is the read-side counterpart of the butterfly address calculator: the calculator's rotated write addressing leaves bin k at address bitrev_M(k), and this block undoes that ordering through a 1-cycle-latency RAM read port behind a valid/ready stream with backpressure.

---
 rtl/fft_out_reader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fft_out_reader.sv
// Unloads FFT results from the working RAM in natural bin order.
// Bin k is read from address bitrev_M(k) through a 1-cycle RAM read port,
// staged through a 2-entry FIFO and presented on a valid/ready stream.
module fft_out_reader #(
    parameter int unsigned width = 16,
    parameter int unsigned M     = 9,
    parameter int unsigned HALF  = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [M-1:0]       rd_adr,
    input  logic [2*width-1:0] rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*width-1:0] out_data,
    output logic [M-1:0]       out_bin,
    output logic               out_last
);

    localparam int unsigned N        = 1 << M;
    localparam int unsigned K        = (HALF != 0) ? N / 2 : N;
    localparam logic [M:0]  LAST_BIN = (M+1)'(K - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [M:0]         issue_cnt;
    logic [M-1:0]       issue_bin;
    logic               issue, start_acc, credit, pop, push, last_pop;
    logic [2:0]         occ;

    logic [M-1:0]       rd_bin;
    logic               rd_last;
    logic               tag_valid, tag_last;
    logic [M-1:0]       tag_bin;

    logic [2*width-1:0] f_data [2];
    logic [M-1:0]       f_bin  [2];
    logic               f_last [2];
    logic               wr_ptr, rd_ptr;
    logic [1:0]         f_count;

    function automatic logic [M-1:0] bitrev(input logic [M-1:0] v);
        logic [M-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < M; i++) r[i] = v[M-1-i];
        return r;
    endfunction

    assign out_valid = (f_count != 2'd0);
    assign out_data  = f_data[rd_ptr];
    assign out_bin   = f_bin[rd_ptr];
    assign out_last  = f_last[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push      = tag_valid;
    assign last_pop  = pop & out_last;

    // Credit: words buffered plus reads still travelling must stay below 2
    // after this cycle's pop, so the FIFO can never overflow.
    always_comb begin
        occ    = 3'(f_count) + 3'(rd_en) + 3'(tag_valid) - 3'(pop);
        credit = (occ < 3'd2);
    end

    // Unload FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and read-issue decision; bin 0 is issued in the start cycle.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        start_acc = 1'b0;
        case (state)
            IDLE: begin
                if (start && !busy) begin
                    start_acc = 1'b1;
                    issue     = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                if (credit) begin
                    issue = 1'b1;
                    if (issue_cnt == LAST_BIN) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        issue_bin = start_acc ? '0 : issue_cnt[M-1:0];
    end

    // Issue counter and registered RAM read strobe/address with bin tags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_cnt <= '0;
            rd_en     <= 1'b0;
            rd_adr    <= '0;
            rd_bin    <= '0;
            rd_last   <= 1'b0;
        end else begin
            rd_en <= issue;
            if (start_acc)  issue_cnt <= (M+1)'(1);
            else if (issue) issue_cnt <= issue_cnt + (M+1)'(1);
            if (issue) begin
                rd_adr  <= bitrev(issue_bin);
                rd_bin  <= issue_bin;
                rd_last <= (issue_bin == LAST_BIN[M-1:0]);
            end
        end
    end

    // One-stage tag delay so bin/last line up with rd_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= 1'b0;
            tag_bin   <= '0;
            tag_last  <= 1'b0;
        end else begin
            tag_valid <= rd_en;
            tag_bin   <= rd_bin;
            tag_last  <= rd_last;
        end
    end

    // Two-entry output FIFO holding {data, bin, last}.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_data  <= '{default: '0};
            f_bin   <= '{default: '0};
            f_last  <= '{default: 1'b0};
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            f_count <= 2'd0;
        end else begin
            if (push) begin
                f_data[wr_ptr] <= rd_data;
                f_bin[wr_ptr]  <= tag_bin;
                f_last[wr_ptr] <= tag_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            f_count <= f_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // busy spans start acceptance through the done pulse; done follows the final handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (state == DRAIN) && last_pop;
            if (start_acc) busy <= 1'b1;
            else if (done) busy <= 1'b0;
        end
    end

endmodule
